// File: rtl/cla16_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cla16_rr_arbiter
//   Shares one 16-bit carry-lookahead adder among NREQ requesters. A rotating
//   priority arbiter picks at most one requester per cycle, its operands are
//   muxed into the adder, and the 17-bit sum lands in a one-entry response
//   slot tagged with the requester index.
//
// Ports
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   REQ_VALID  [NREQ]     requester i presents an operand pair
//   REQ_READY  [NREQ]     requester i accepted this cycle (one-hot or zero)
//   REQ_IN1    [16*NREQ]  operand A, requester i at [16*i+15:16*i]
//   REQ_IN2    [16*NREQ]  operand B, same packing
//   RSP_VALID             response slot full
//   RSP_READY             consumer takes the response
//   RSP_SUM    [17]       registered IN1+IN2, carry in bit 16
//   RSP_ID     [IDW]      index of the requester that produced RSP_SUM
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead group with group propagate/generate outputs.
module cla4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_c,
   output logic [3:0] o_s,
   output logic       o_p,
   output logic       o_g
);
   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [3:0] w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   assign w_c[0] = i_c;
   assign w_c[1] = w_g[0] | (w_p[0] & i_c);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_c);

   assign o_s = w_p ^ w_c;
   assign o_p = &w_p;
   assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

// 16-bit adder: four cla4 groups joined by a second-level lookahead unit.
// Carry-in is fixed at 0, so the group-level carry terms drop the cin product.
module cla16 (
   input  logic [15:0] IN1,
   input  logic [15:0] IN2,
   output logic [16:0] SUM
);
   logic [3:0] w_gp;
   logic [3:0] w_gg;
   logic [4:0] w_gc;

   assign w_gc[0] = 1'b0;
   assign w_gc[1] = w_gg[0];
   assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]);
   assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0]);
   assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);

   for (genvar g = 0; g < 4; g++) begin : g_grp
      cla4 u_cla4 (
         .i_a (IN1[4*g +: 4]),
         .i_b (IN2[4*g +: 4]),
         .i_c (w_gc[g]),
         .o_s (SUM[4*g +: 4]),
         .o_p (w_gp[g]),
         .o_g (w_gg[g])
      );
   end

   assign SUM[16] = w_gc[4];
endmodule

module cla16_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NREQ-1:0]      REQ_VALID,
   output logic [NREQ-1:0]      REQ_READY,
   input  logic [16*NREQ-1:0]   REQ_IN1,
   input  logic [16*NREQ-1:0]   REQ_IN2,
   output logic                 RSP_VALID,
   input  logic                 RSP_READY,
   output logic [16:0]          RSP_SUM,
   output logic [IDW-1:0]       RSP_ID
);
   if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ)) begin : g_bad_param
      $error("cla16_rr_arbiter: NREQ must be 2..8 and IDW must equal clog2(NREQ)");
   end

   logic            r_vld;
   logic [16:0]     r_sum;
   logic [IDW-1:0]  r_id;
   logic [IDW-1:0]  r_ptr;

   logic            w_found;
   logic [IDW-1:0]  w_win;
   logic            w_open;
   logic            w_xfer;
   logic [NREQ-1:0] w_ready;
   logic [15:0]     w_in1;
   logic [15:0]     w_in2;
   logic [16:0]     w_sum;
   logic [IDW-1:0]  w_ptr_nxt;

   // Rotating priority search: scan upward from r_ptr with wrap, first hit wins.
   always_comb begin
      int w_idx;
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (!w_found && REQ_VALID[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx[IDW-1:0];
         end
      end
   end

   // Slot can take a new result when empty or being drained this same cycle.
   assign w_open = !r_vld || RSP_READY;
   assign w_xfer = w_found && w_open && !RST;

   always_comb begin
      w_ready = '0;
      if (w_xfer) w_ready[w_win] = 1'b1;
   end
   assign REQ_READY = w_ready;

   // Adder inputs parked at zero when nobody is requesting.
   assign w_in1 = w_found ? REQ_IN1[16*w_win +: 16] : 16'h0000;
   assign w_in2 = w_found ? REQ_IN2[16*w_win +: 16] : 16'h0000;

   cla16 u_cla16 (
      .IN1 (w_in1),
      .IN2 (w_in2),
      .SUM (w_sum)
   );

   // Explicit wrap so non-power-of-two NREQ cycles correctly.
   assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_vld <= 1'b0;
         r_sum <= '0;
         r_id  <= '0;
         r_ptr <= '0;
      end else if (w_xfer) begin
         r_vld <= 1'b1;
         r_sum <= w_sum;
         r_id  <= w_win;
         r_ptr <= w_ptr_nxt;
      end else if (r_vld && RSP_READY) begin
         r_vld <= 1'b0;
      end
   end

   assign RSP_VALID = r_vld;
   assign RSP_SUM   = r_sum;
   assign RSP_ID    = r_id;
endmodule
